king_status_scanner: RTL and testbench
======================================

Name: king_status_scanner

Overview:
- Sequential king-safety evaluator for the chess datapath.
- On a start pulse it snapshots the board and locates the selected side's king.
- It then determines whether that king is attacked and which of its 8 neighbour squares are safe escapes, and derives the game result.
- Ray-walking engine, one board square examined per cycle; it replaces the per-neighbour combinational checker array and generalises to any board size.

Parameters:
- BOARD_W, 8, number of files.
- BOARD_H, 8, number of ranks.
- SQ_BITS, 4, bits per square code. Fixed format: [3] colour (0 white, 1 black), [2:0] type (0 empty, 1 pawn, 2 knight, 3 bishop, 4 rook, 5 queen, 6 king).
- IDX_W, 7, square index width; must satisfy 2^IDX_W >= BOARD_W*BOARD_H.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- start  in  1  one-cycle request; ignored while busy.
- side  in  1  colour of king to evaluate (0 white, 1 black).
- board  in  BOARD_W*BOARD_H*SQ_BITS  square s = board[s*SQ_BITS +: SQ_BITS], where s = rank*BOARD_W + file and rank 0 is white's back rank.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; result outputs are valid from this cycle on.
- king_found  out  1  king of side located.
- king_pos  out  IDX_W  located king square.
- in_check  out  1  king square attacked by the opponent.
- escape_mask  out  8  bit order 0 N, 1 NE, 2 E, 3 SE, 4 S, 5 SW, 6 W, 7 NW (N = rank+1).
- win_state  out  2  00 continue, 01 white win, 10 black win, 11 draw.

Behaviour:
- Reset: all outputs 0; FSM returns to IDLE from any state; the in-flight scan is discarded and no done pulse is produced.
- IDLE:
  - start=1 snapshots board and side into internal registers; the FSM moves to FIND.
  - Later changes on board or side have no effect until the next start.
- FIND:
  - Scans squares 0..N-1, one per cycle.
  - Latches the lowest-index square holding the king of side.
  - Counts non-king pieces of side (own_other flag).
  - Exit: no king found -> DONE with king_found=0, in_check=0, escape_mask=0, win_state = opponent wins. Otherwise -> EVAL with target = king square.
- EVAL, per target (the king square first, then neighbours N..NW in order):
  - Neighbour skip rule: a neighbour that is off-board (no file/rank wrap) or occupied by an own piece is skipped in 1 cycle with its mask bit 0.
  - Rays: 8 directions, each walked outward one square per cycle. A ray stops at the board edge or at the first occupied square.
    - The evaluated king's own square is treated as empty.
    - The blocker attacks the target if:
      - it is an opponent rook/queen on an orthogonal ray;
      - it is an opponent bishop/queen on a diagonal ray;
      - it is an opponent king at distance 1;
      - it is an opponent pawn at distance 1 on a forward diagonal. For a white target this is rank+1; for a black target rank-1.
  - Knights: 8 offset checks, 1 cycle each, on-board only.
  - Attacked king square -> in_check=1. A neighbour not attacked -> escape bit 1.
- Result:
  - in_check && escape_mask==0 -> opponent wins (01 or 10). This is king-only mate detection: blocks and captures by other pieces are not considered.
  - !in_check && escape_mask==0 && !own_other -> 11 draw.
  - Otherwise -> 00.
- DONE:
  - done=1 for one cycle, busy drops the same cycle, FSM returns to IDLE.
  - Outputs hold until the next accepted start; they clear to 0 on that start.
- Latency bound: at most N + 9*(8*(max(BOARD_W,BOARD_H)-1) + 8) + 3 cycles from start to done (643 for 8x8).
- A start pulse arriving in the same cycle as done is ignored.

Optional Feature:
- Macro: KING_SCAN_EARLY_EXIT_EN.
- Defined: evaluation of a target terminates on the first attack found, skipping its remaining rays and knight checks. Latency drops, results are identical.
- Undefined: every target runs its full fixed sequence, so latency depends only on board geometry and occupancy, never on attack outcome.

Test Plan:
- Standard start position, side=0 -> king_found=1, king_pos=4, in_check=0, escape_mask=0x00, win_state=00.
- White K g1(6), P f2(13) g2(14) h2(15), black R a1(0), black K h8(63), side=0 -> in_check=1, escape_mask=0x00, win_state=10.
- Black K a8(56), white Q b6(41), white K h1(7), side=1 -> in_check=0, escape_mask=0x00, win_state=11.
- White K e1(4), black N d3(19), black K h8(63), side=0 -> in_check=1, escape_mask=0xC5, win_state=00.
- Empty board except white K e1, side=1 -> king_found=0, win_state=01. Then assert reset=0 mid-scan of a new start -> busy=0, no done pulse, all outputs 0.
- Board input changed each cycle during a scan, and start pulsed while busy -> results match the snapshot and the extra start is ignored. Run with and without KING_SCAN_EARLY_EXIT_EN; results are identical in both builds.

Source files
------------

// File: rtl/king_status_scanner.sv
// -----------------------------------------------------------------------------
// king_status_scanner
//
// Sequential king-safety evaluator. A start pulse snapshots the board and the
// side to evaluate. The scanner then finds that side's king and decides whether
// the king is attacked. It also decides which of the king's 8 neighbour squares
// are safe escapes, and from these it derives the game result. The engine walks
// rays one board square per cycle, so it works for any board size.
//
// Optional feature macro: KING_SCAN_EARLY_EXIT_EN
//   defined   : a target's evaluation stops at the first attack found
//   undefined : every target runs its full ray + knight sequence
//
// Ports:
//   clk          system clock
//   reset        synchronous active-low reset
//   start        one-cycle request, ignored unless idle
//   side         colour of the king to evaluate (0 white, 1 black)
//   board        packed board, square s at board[s*SQ_BITS +: SQ_BITS]
//   busy         high while a scan is in flight
//   done         one-cycle pulse, results valid from this cycle
//   king_found   king of side located
//   king_pos     located king square index
//   in_check     king square attacked by the opponent
//   escape_mask  safe neighbours, bit 0 N, 1 NE, 2 E, 3 SE, 4 S, 5 SW, 6 W, 7 NW
//   win_state    00 continue, 01 white win, 10 black win, 11 draw
// -----------------------------------------------------------------------------
module king_status_scanner #(
  parameter int BOARD_W = 8,
  parameter int BOARD_H = 8,
  parameter int SQ_BITS = 4,
  parameter int IDX_W   = 7
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               side,
  input  logic [BOARD_W*BOARD_H*SQ_BITS-1:0] board,
  output logic                               busy,
  output logic                               done,
  output logic                               king_found,
  output logic [IDX_W-1:0]                   king_pos,
  output logic                               in_check,
  output logic [7:0]                         escape_mask,
  output logic [1:0]                         win_state
);

  localparam int N      = BOARD_W * BOARD_H;
  localparam int BV     = N * SQ_BITS;
  localparam int BSEL_W = $clog2(BV);

`ifdef KING_SCAN_EARLY_EXIT_EN
  localparam logic EARLY_EXIT = 1'b1;
`else
  localparam logic EARLY_EXIT = 1'b0;
`endif

  localparam logic [2:0] T_EMPTY  = 3'd0;
  localparam logic [2:0] T_PAWN   = 3'd1;
  localparam logic [2:0] T_KNIGHT = 3'd2;
  localparam logic [2:0] T_BISHOP = 3'd3;
  localparam logic [2:0] T_ROOK   = 3'd4;
  localparam logic [2:0] T_QUEEN  = 3'd5;
  localparam logic [2:0] T_KING   = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE, S_FIND, S_TGT, S_RAY, S_KNIGHT, S_DONE
  } state_t;

  // Direction deltas, in escape_mask order (N = rank+1).
  function automatic int dir_df(input logic [2:0] d);
    case (d)
      3'd1, 3'd2, 3'd3: return 1;
      3'd5, 3'd6, 3'd7: return -1;
      default:          return 0;
    endcase
  endfunction

  function automatic int dir_dr(input logic [2:0] d);
    case (d)
      3'd0, 3'd1, 3'd7: return 1;
      3'd3, 3'd4, 3'd5: return -1;
      default:          return 0;
    endcase
  endfunction

  function automatic int kn_df(input logic [2:0] k);
    case (k)
      3'd0, 3'd3: return 1;
      3'd1, 3'd2: return 2;
      3'd4, 3'd7: return -1;
      default:    return -2;
    endcase
  endfunction

  function automatic int kn_dr(input logic [2:0] k);
    case (k)
      3'd0, 3'd7: return 2;
      3'd1, 3'd6: return 1;
      3'd2, 3'd5: return -1;
      default:    return -2;
    endcase
  endfunction

  function automatic logic on_board(input int f, input int r);
    return (f >= 0) && (f < BOARD_W) && (r >= 0) && (r < BOARD_H);
  endfunction

  function automatic logic [SQ_BITS-1:0] sq_at(input logic [BV-1:0] b, input int idx);
    logic [BSEL_W-1:0] bit_pos;
    bit_pos = BSEL_W'(idx * SQ_BITS);
    return b[bit_pos +: SQ_BITS];
  endfunction

  // Does the first occupied square met on ray d attack the target?
  function automatic logic ray_attacks(input logic [SQ_BITS-1:0] sq, input logic [2:0] d,
                                       input logic first, input logic sd);
    logic       opp;
    logic       orth;
    logic [2:0] typ;
    logic       pawn_dir;
    opp      = (sq[3] != sd);
    typ      = sq[2:0];
    orth     = ~d[0];
    // Enemy pawns attack toward the target's side: from rank+1 for white, rank-1 for black.
    pawn_dir = sd ? ((d == 3'd3) || (d == 3'd5)) : ((d == 3'd1) || (d == 3'd7));
    return opp && ((orth && (typ == T_ROOK || typ == T_QUEEN)) ||
                   (!orth && (typ == T_BISHOP || typ == T_QUEEN)) ||
                   (first && typ == T_KING) ||
                   (first && typ == T_PAWN && pawn_dir));
  endfunction

  function automatic logic [1:0] opp_win(input logic sd);
    return sd ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] game_result(input logic chk, input logic [7:0] m,
                                             input logic own, input logic sd);
    if (chk && m == 8'h00) return opp_win(sd);
    else if (!chk && m == 8'h00 && !own) return 2'b11;
    else return 2'b00;
  endfunction

  state_t             state_q, state_d;
  logic [BV-1:0]      board_q, board_d;
  logic               side_q, side_d;
  logic [IDX_W-1:0]   idx_q, idx_d, ff_q, ff_d, fr_q, fr_d;
  logic               kfound_q, kfound_d, own_other_q, own_other_d;
  logic [IDX_W-1:0]   kpos_q, kpos_d, kf_q, kf_d, kr_q, kr_d;
  logic [3:0]         t_q, t_d;
  logic [IDX_W-1:0]   tf_q, tf_d, tr_q, tr_d, cf_q, cf_d, cr_q, cr_d;
  logic [2:0]         dir_q, dir_d, k_q, k_d;
  logic               first_q, first_d, att_q, att_d, chk_q, chk_d;
  logic [7:0]         mask_q, mask_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               found_q, found_d, incheck_q, incheck_d;
  logic [IDX_W-1:0]   pos_q, pos_d;
  logic [7:0]         emask_q, emask_d;
  logic [1:0]         win_q, win_d;

  logic [SQ_BITS-1:0] sq_s;
  logic [2:0]         tdir_s;
  int                 nf_s, nr_s;
  logic               skip_s, ray_end_s, hit_s, fin_s, fin_att_s, fin_skip_s;

  // Next-state logic: board scan, per-target ray/knight walk and result publish.
  always_comb begin
    state_d = state_q;  board_d = board_q;  side_d = side_q;
    idx_d = idx_q;  ff_d = ff_q;  fr_d = fr_q;
    kfound_d = kfound_q;  kpos_d = kpos_q;  kf_d = kf_q;  kr_d = kr_q;
    own_other_d = own_other_q;  t_d = t_q;  tf_d = tf_q;  tr_d = tr_q;
    cf_d = cf_q;  cr_d = cr_q;  dir_d = dir_q;  k_d = k_q;
    first_d = first_q;  att_d = att_q;  chk_d = chk_q;  mask_d = mask_q;
    found_d = found_q;  pos_d = pos_q;  incheck_d = incheck_q;
    emask_d = emask_q;  win_d = win_q;
    sq_s = '0;  nf_s = 0;  nr_s = 0;  tdir_s = 3'(t_q - 4'd1);
    skip_s = 1'b0;  ray_end_s = 1'b0;  hit_s = 1'b0;
    fin_s = 1'b0;  fin_att_s = 1'b0;  fin_skip_s = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          board_d = board;  side_d = side;
          idx_d = '0;  ff_d = '0;  fr_d = '0;
          kfound_d = 1'b0;  kpos_d = '0;  kf_d = '0;  kr_d = '0;
          own_other_d = 1'b0;
          found_d = 1'b0;  pos_d = '0;  incheck_d = 1'b0;
          emask_d = 8'h00;  win_d = 2'b00;
          state_d = S_FIND;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_FIND: begin
        sq_s = sq_at(board_q, int'(idx_q));
        if (sq_s[2:0] != T_EMPTY && sq_s[3] == side_q) begin
          if (sq_s[2:0] == T_KING) begin
            if (!kfound_q) begin
              kfound_d = 1'b1;  kpos_d = idx_q;  kf_d = ff_q;  kr_d = fr_q;
            end else begin
              kfound_d = kfound_q;
            end
          end else begin
            own_other_d = 1'b1;
          end
        end else begin
          own_other_d = own_other_q;
        end
        if (int'(idx_q) == N - 1) begin
          if (kfound_d) begin
            t_d = 4'd0;  chk_d = 1'b0;  mask_d = 8'h00;
            state_d = S_TGT;
          end else begin
            found_d = 1'b0;  pos_d = '0;  incheck_d = 1'b0;
            emask_d = 8'h00;  win_d = opp_win(side_q);
            state_d = S_DONE;
          end
        end else begin
          idx_d = idx_q + IDX_W'(1);
          if (int'(ff_q) == BOARD_W - 1) begin
            ff_d = '0;  fr_d = fr_q + IDX_W'(1);
          end else begin
            ff_d = ff_q + IDX_W'(1);
          end
        end
      end

      // Target setup: target 0 is the king, targets 1..8 its neighbours.
      S_TGT: begin
        if (t_q == 4'd0) begin
          nf_s = int'(kf_q);  nr_s = int'(kr_q);
        end else begin
          nf_s = int'(kf_q) + dir_df(tdir_s);
          nr_s = int'(kr_q) + dir_dr(tdir_s);
          if (!on_board(nf_s, nr_s)) begin
            skip_s = 1'b1;
          end else begin
            sq_s   = sq_at(board_q, nr_s * BOARD_W + nf_s);
            skip_s = (sq_s[2:0] != T_EMPTY) && (sq_s[3] == side_q);
          end
        end
        if (skip_s) begin
          fin_s = 1'b1;  fin_skip_s = 1'b1;
        end else begin
          tf_d = IDX_W'(nf_s);  tr_d = IDX_W'(nr_s);
          cf_d = IDX_W'(nf_s);  cr_d = IDX_W'(nr_s);
          dir_d = 3'd0;  first_d = 1'b1;  att_d = 1'b0;
          state_d = S_RAY;
        end
      end

      S_RAY: begin
        nf_s = int'(cf_q) + dir_df(dir_q);
        nr_s = int'(cr_q) + dir_dr(dir_q);
        if (!on_board(nf_s, nr_s)) begin
          ray_end_s = 1'b1;
        end else begin
          sq_s = sq_at(board_q, nr_s * BOARD_W + nf_s);
          // The evaluated king's own square is transparent (the king has moved away).
          if (sq_s[2:0] == T_EMPTY || (nr_s * BOARD_W + nf_s) == int'(kpos_q)) begin
            cf_d = IDX_W'(nf_s);  cr_d = IDX_W'(nr_s);  first_d = 1'b0;
            // Look one step ahead so an unblocked ray ends on its last square.
            ray_end_s = !on_board(nf_s + dir_df(dir_q), nr_s + dir_dr(dir_q));
          end else begin
            ray_end_s = 1'b1;
            hit_s     = ray_attacks(sq_s, dir_q, first_q, side_q);
          end
        end
        att_d = att_q | hit_s;
        if (EARLY_EXIT && hit_s) begin
          fin_s = 1'b1;  fin_att_s = 1'b1;
        end else if (ray_end_s) begin
          if (dir_q == 3'd7) begin
            k_d = 3'd0;  state_d = S_KNIGHT;
          end else begin
            dir_d = dir_q + 3'd1;  cf_d = tf_q;  cr_d = tr_q;  first_d = 1'b1;
          end
        end else begin
          state_d = S_RAY;
        end
      end

      S_KNIGHT: begin
        nf_s = int'(tf_q) + kn_df(k_q);
        nr_s = int'(tr_q) + kn_dr(k_q);
        if (on_board(nf_s, nr_s)) begin
          sq_s  = sq_at(board_q, nr_s * BOARD_W + nf_s);
          hit_s = (sq_s[3] != side_q) && (sq_s[2:0] == T_KNIGHT);
        end else begin
          hit_s = 1'b0;
        end
        att_d = att_q | hit_s;
        if (k_q == 3'd7 || (EARLY_EXIT && hit_s)) begin
          fin_s = 1'b1;  fin_att_s = att_q | hit_s;
        end else begin
          k_d = k_q + 3'd1;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    // Close the current target; after the last neighbour publish the results.
    if (fin_s) begin
      if (t_q == 4'd0) begin
        chk_d = fin_att_s;
      end else begin
        mask_d[tdir_s] = !fin_skip_s && !fin_att_s;
      end
      if (t_q == 4'd8) begin
        found_d = 1'b1;  pos_d = kpos_q;  incheck_d = chk_d;
        emask_d = mask_d;
        win_d   = game_result(chk_d, mask_d, own_other_q, side_q);
        state_d = S_DONE;
      end else begin
        t_d = t_q + 4'd1;  state_d = S_TGT;
      end
    end else begin
      t_d = t_d;
    end

    busy_d = (state_d == S_FIND) || (state_d == S_TGT) ||
             (state_d == S_RAY)  || (state_d == S_KNIGHT);
    done_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;  board_q <= '0;  side_q <= 1'b0;
      idx_q <= '0;  ff_q <= '0;  fr_q <= '0;
      kfound_q <= 1'b0;  kpos_q <= '0;  kf_q <= '0;  kr_q <= '0;
      own_other_q <= 1'b0;  t_q <= 4'd0;  tf_q <= '0;  tr_q <= '0;
      cf_q <= '0;  cr_q <= '0;  dir_q <= 3'd0;  k_q <= 3'd0;
      first_q <= 1'b0;  att_q <= 1'b0;  chk_q <= 1'b0;  mask_q <= 8'h00;
      busy_q <= 1'b0;  done_q <= 1'b0;
      found_q <= 1'b0;  pos_q <= '0;  incheck_q <= 1'b0;
      emask_q <= 8'h00;  win_q <= 2'b00;
    end else begin
      state_q <= state_d;  board_q <= board_d;  side_q <= side_d;
      idx_q <= idx_d;  ff_q <= ff_d;  fr_q <= fr_d;
      kfound_q <= kfound_d;  kpos_q <= kpos_d;  kf_q <= kf_d;  kr_q <= kr_d;
      own_other_q <= own_other_d;  t_q <= t_d;  tf_q <= tf_d;  tr_q <= tr_d;
      cf_q <= cf_d;  cr_q <= cr_d;  dir_q <= dir_d;  k_q <= k_d;
      first_q <= first_d;  att_q <= att_d;  chk_q <= chk_d;  mask_q <= mask_d;
      busy_q <= busy_d;  done_q <= done_d;
      found_q <= found_d;  pos_q <= pos_d;  incheck_q <= incheck_d;
      emask_q <= emask_d;  win_q <= win_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign king_found  = found_q;
  assign king_pos    = pos_q;
  assign in_check    = incheck_q;
  assign escape_mask = emask_q;
  assign win_state   = win_q;

endmodule

// File: tb/tb_king_status_scanner.sv
// Scoreboard bench for king_status_scanner: stimulus pushes hand-computed
// expected results, a monitor pops and compares on every done pulse.
module tb_king_status_scanner;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int SB = 4;
  localparam int IW = 7;
  localparam int BV = W * H * SB;
  localparam int LAT_MAX = 643;

  logic          clk = 1'b0;
  logic          reset, start, side;
  logic [BV-1:0] board;
  logic          busy, done, king_found, in_check;
  logic [IW-1:0] king_pos;
  logic [7:0]    escape_mask;
  logic [1:0]    win_state;

  typedef struct packed {
    logic          found;
    logic [IW-1:0] pos;
    logic          chk;
    logic [7:0]    mask;
    logic [1:0]    win;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks   = 0;
  int    failures = 0;

  king_status_scanner #(.BOARD_W(W), .BOARD_H(H), .SQ_BITS(SB), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .start(start), .side(side), .board(board),
    .busy(busy), .done(done), .king_found(king_found), .king_pos(king_pos),
    .in_check(in_check), .escape_mask(escape_mask), .win_state(win_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic exp_t mk(input logic f, input int p, input logic c,
                              input logic [7:0] m, input logic [1:0] w);
    exp_t e;
    e.found = f;  e.pos = IW'(p);  e.chk = c;  e.mask = m;  e.win = w;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t  e;
    string nm;
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check({nm, "_found"}, 32'(king_found), 32'(e.found));
        check({nm, "_pos"},   32'(king_pos),   32'(e.pos));
        check({nm, "_check"}, 32'(in_check),   32'(e.chk));
        check({nm, "_mask"},  32'(escape_mask), 32'(e.mask));
        check({nm, "_win"},   32'(win_state),  32'(e.win));
        check({nm, "_busy_at_done"}, 32'(busy), 32'd0);
      end
    end
  end

  task automatic put(input int s, input logic [3:0] code);
    logic [7:0] bp;
    bp = 8'(s * SB);
    board[bp +: SB] = code;
  endtask

  task automatic std_board();
    logic [3:0] back [8];
    back = '{4'd4, 4'd2, 4'd3, 4'd5, 4'd6, 4'd3, 4'd2, 4'd4};
    board = '0;
    for (int f = 0; f < 8; f++) begin
      put(f, back[f]);
      put(8 + f, 4'd1);
      put(48 + f, 4'd9);
      put(56 + f, back[f] | 4'h8);
    end
  endtask

  task automatic run_case(input string nm, input logic sd, input exp_t e, input bit scramble);
    int lat;
    bit got;
    @(negedge clk);
    side = sd;  start = 1'b1;
    exp_q.push_back(e);  name_q.push_back(nm);
    @(negedge clk);
    start = 1'b0;
    check({nm, "_busy_after_start"}, 32'(busy), 32'd1);
    check({nm, "_cleared_on_start"},
          32'({king_found, king_pos, in_check, escape_mask, win_state}), 32'd0);
    lat = 1;  got = 1'b0;
    for (int i = 0; i < LAT_MAX + 20; i++) begin
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (scramble) begin
        board = {8{$urandom()}};
        side  = ~side;
        start = (i == 4);
      end
      @(negedge clk);
      lat++;
    end
    check({nm, "_done_seen"}, 32'(got), 32'd1);
    if (got) begin
      check({nm, "_latency_ok"}, 32'(lat <= LAT_MAX), 32'd1);
      if (scramble) begin
        // Start coinciding with done must be ignored.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check({nm, "_start_at_done_ignored"}, 32'(busy), 32'd0);
      end else begin
        repeat (3) @(negedge clk);
      end
    end else begin
      exp_q.delete();  name_q.delete();
    end
  endtask

  initial begin
    int n_done;
    reset = 1'b0;  start = 1'b0;  side = 1'b0;  board = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_outs",  32'({king_found, king_pos, in_check, escape_mask, win_state}), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    std_board();
    run_case("std_start", 1'b0, mk(1'b1, 4, 1'b0, 8'h00, 2'b00), 1'b0);

    board = '0;
    put(6, 4'h6);  put(13, 4'h1);  put(14, 4'h1);  put(15, 4'h1);
    put(0, 4'hC);  put(63, 4'hE);
    run_case("back_rank_mate", 1'b0, mk(1'b1, 6, 1'b1, 8'h00, 2'b10), 1'b0);

    board = '0;
    put(56, 4'hE);  put(41, 4'h5);  put(7, 4'h6);
    run_case("stalemate", 1'b1, mk(1'b1, 56, 1'b0, 8'h00, 2'b11), 1'b0);

    board = '0;
    put(4, 4'h6);  put(19, 4'hA);  put(63, 4'hE);
    run_case("knight_check", 1'b0, mk(1'b1, 4, 1'b1, 8'hC5, 2'b00), 1'b0);

    board = '0;
    put(4, 4'h6);
    run_case("no_black_king", 1'b1, mk(1'b0, 0, 1'b0, 8'h00, 2'b01), 1'b0);

    // Reset in the middle of a scan: no done pulse, everything cleared.
    std_board();
    @(negedge clk);
    side = 1'b0;  start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("midscan_busy_before_reset", 32'(busy), 32'd1);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("midscan_rst_busy", 32'(busy), 32'd0);
    check("midscan_rst_done", 32'(done), 32'd0);
    check("midscan_rst_outs", 32'({king_found, king_pos, in_check, escape_mask, win_state}), 32'd0);
    reset = 1'b1;
    n_done = 0;
    repeat (LAT_MAX + 20) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    check("midscan_no_done", 32'(n_done), 32'd0);

    board = '0;
    put(56, 4'hE);  put(41, 4'h5);  put(7, 4'h6);
    run_case("stalemate_after_reset", 1'b1, mk(1'b1, 56, 1'b0, 8'h00, 2'b11), 1'b0);

    // Board/side scrambled during the scan, extra start while busy.
    board = '0;
    put(4, 4'h6);  put(19, 4'hA);  put(63, 4'hE);
    run_case("snapshot_scramble", 1'b0, mk(1'b1, 4, 1'b1, 8'hC5, 2'b00), 1'b1);

    repeat (5) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
